// File: rtl/tag_allocator_pkg.sv
// tag_allocator_pkg: shared state encoding and default sizes for the tag allocator.
package tag_allocator_pkg;
   localparam int INDEX_BITS = 3;
   localparam int ADDR_WIDTH = 32;
   typedef enum logic {INIT, READY} state_t;
endpackage

// File: rtl/tag_allocator_tag_ring.sv
// tag_ring: circular FIFO of free tags with head/tail pointers and occupancy count.
module tag_ring
   import tag_allocator_pkg::*;
#(
   parameter int index_bits = INDEX_BITS
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  push,
   input  logic [index_bits-1:0] push_tag,
   input  logic                  pop,
   output logic [index_bits-1:0] head_tag,
   output logic [index_bits:0]   count
);
   localparam int N = 1 << index_bits;
   logic [index_bits-1:0] ring [N];
   logic [index_bits-1:0] head, tail;
   // Pointers are exactly index_bits wide, so wrapping modulo N is free.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + index_bits'(1);
         if (pop) head <= head + index_bits'(1);
         count <= count + (index_bits+1)'(push) - (index_bits+1)'(pop);
      end
   end
   always_ff @(posedge clk) begin
      if (push) ring[tail] <= push_tag;
   end
   assign head_tag = ring[head];
endmodule

// File: rtl/tag_allocator.sv
// tag_allocator: hands out tags from a free ring, binds each to an address,
// and supports retire and associative lookup of outstanding tags.
module tag_allocator
   import tag_allocator_pkg::*;
#(
   parameter int index_bits = INDEX_BITS,
   parameter int addr_width = ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic                  alloc_req,
   input  logic [addr_width-1:0] alloc_addr,
   output logic                  alloc_grant,
   output logic [index_bits-1:0] alloc_tag,
   input  logic                  retire_valid,
   input  logic [index_bits-1:0] retire_tag,
   output logic [addr_width-1:0] retire_addr,
   output logic                  retire_err,
   input  logic [addr_width-1:0] lookup_addr,
   output logic                  lookup_hit,
   output logic [index_bits-1:0] lookup_tag,
   output logic [index_bits:0]   outstanding,
   output logic                  ready
);
   localparam int N = 1 << index_bits;
   state_t state, state_nx;
   logic [N-1:0] valid;
   logic [addr_width-1:0] addr_mem [N];
   logic [index_bits:0] free_cnt;
   logic legal, push;
   logic [index_bits-1:0] push_tag;
   assign ready       = state == READY;
   assign alloc_grant = alloc_req & ready & (free_cnt != '0);
   assign legal       = retire_valid & ready & valid[retire_tag];
   assign retire_addr = addr_mem[retire_tag];
   // During INIT the ring count doubles as the next tag to seed.
   always_comb begin
      state_nx = (state == INIT && enable && free_cnt == (index_bits+1)'(N-1)) ? READY : state;
      push     = enable & (ready ? legal : 1'b1);
      push_tag = ready ? retire_tag : free_cnt[index_bits-1:0];
   end
   tag_ring #(.index_bits(index_bits)) u_ring (
      .clk      (clk),
      .reset_n  (reset_n),
      .push     (push),
      .push_tag (push_tag),
      .pop      (enable & alloc_grant),
      .head_tag (alloc_tag),
      .count    (free_cnt)
   );
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= INIT;
      else state <= state_nx;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid       <= '0;
         outstanding <= '0;
         retire_err  <= 1'b0;
      end else if (enable) begin
         if (alloc_grant) valid[alloc_tag] <= 1'b1;
         if (legal) valid[retire_tag] <= 1'b0;
         outstanding <= outstanding + (index_bits+1)'(alloc_grant) - (index_bits+1)'(legal);
         retire_err  <= retire_valid & ~legal;
      end
   end
   always_ff @(posedge clk) begin
      if (enable & alloc_grant) addr_mem[alloc_tag] <= alloc_addr;
   end
   always_comb begin
      lookup_hit = 1'b0;
      lookup_tag = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (valid[i] && addr_mem[i] == lookup_addr) begin
            lookup_hit = 1'b1;
            lookup_tag = index_bits'(i);
         end
      end
   end
endmodule
